circuit_sweep_ctrl: RTL and testbench
=====================================

// Module: circuit_sweep_ctrl
// PURPOSE
// - Sequencer that exhaustively exercises a small combinational logic block (e.g. Circuit5: out = ~(A&B) | (B&C)).
// - Drives every input vector, waits a settle time, samples the block output and checks it against a truth table.
// - Reports pass/fail, the error count and the first failing vector.
// - Sits between the board start/abort controls and the DUT's input/output pins; one controller per circuit under check.
// PARAMETERS
// - N_IN    3      number of DUT inputs; vectors 0 .. 2**N_IN-1.
// - SETTLE  1      wait cycles between driving a vector and sampling it; legal range 1..15.
// - EXPECT  8'hBF  expected output per vector, 2**N_IN bits; bit i = expected out for drive_vec == i (hBF = Circuit5).
// PORTS
// - clk             in   1       rising-edge clock
// - rst_n           in   1       asynchronous active-low reset
// - start           in   1       1-cycle request to begin a sweep; sampled only in IDLE
// - abort           in   1       cancel a running sweep
// - drive_vec       out  N_IN    DUT inputs; MSB = A, LSB = C for Circuit5
// - dut_out         in   1       DUT output
// - busy            out  1       high from the cycle after an accepted start until the sweep ends
// - done            out  1       1-cycle pulse at sweep completion; not raised on abort
// - pass            out  1       1 if the last completed sweep had err_count == 0; held until the next accepted start
// - err_count       out  N_IN+1  mismatches in the current or last sweep; saturates at 2**N_IN
// - fail_valid      out  1       at least one mismatch recorded
// - first_fail_idx  out  N_IN    vector of the first mismatch; valid only when fail_valid = 1
// BEHAVIOUR
// - Reset (async, rst_n = 0): state = IDLE; all outputs 0; idx = 0; settle counter = 0.
// - All outputs are registered. dut_out is sampled once per vector, only in SAMPLE.
// - IDLE: start = 1 -> DRIVE.
//   - On that edge: idx, err_count, fail_valid, first_fail_idx and pass are cleared.
//   - start is ignored in every other state.
// - DRIVE (1 cycle): drive_vec <= idx; reload the settle counter with SETTLE -> WAIT.
// - WAIT (SETTLE cycles): count down; when the count reaches 1 -> SAMPLE.
// - SAMPLE (1 cycle): mismatch = dut_out != EXPECT[idx].
//   - On a mismatch: err_count++; if fail_valid = 0, set first_fail_idx = idx and fail_valid = 1.
//   - If idx == 2**N_IN-1 -> DONE; otherwise idx++ -> DRIVE.
// - DONE (1 cycle): done = 1; pass = (err_count == 0); busy = 0 -> IDLE.
// - Timing: each vector takes SETTLE+2 cycles. With start accepted at edge k, done is high in cycle k + 2**N_IN*(SETTLE+2) + 1.
// - abort (any non-IDLE state, priority over all other transitions):
//   - next state IDLE; busy = 0; done = 0; pass = 0; drive_vec = 0.
//   - err_count, fail_valid and first_fail_idx keep their partial values.
// - Simultaneous start and abort in IDLE: abort wins and start is dropped.
// - idx wrap: the last vector never increments idx, so no wrap to 0 occurs mid-sweep.
// - Async reset mid-sweep: immediate return to reset values; no done pulse.
// - drive_vec holds its value in WAIT and SAMPLE and keeps the last vector after DONE.
// STRUCTURE
// - Package circuit_pkg:
//   - state enum {IDLE, DRIVE, WAIT, SAMPLE, DONE}
//   - localparam CIRCUIT5_EXPECT = 8'hBF
//   - function n_vectors(N_IN) = 2**N_IN
// - Sub-module settle_timer (load, value[3:0], expire): reused by other circuit controllers.
// - FSM, idx counter and error bookkeeping live in the top level.
// TESTING
// - Bench defaults: N_IN = 3, SETTLE = 1, real Circuit5 connected.
// - Golden sweep: start pulse -> busy for 24 cycles; done at k+25; pass = 1, err_count = 0, fail_valid = 0; drive_vec visits 0..7 in order.
// - Stuck-at-1 (dut_out tied 1): pass = 0, err_count = 1, first_fail_idx = 6.
// - Stuck-at-0 (dut_out tied 0): err_count = 7, first_fail_idx = 0, fail_valid = 1.
// - Start while busy at idx 4: ignored; sweep finishes with one done pulse at the original time.
// - abort in WAIT of vector 3: next cycle busy = 0, drive_vec = 0, no done pulse. A following start restarts at idx 0 with counters cleared.
// - rst_n low mid-SAMPLE (asynchronous, off-edge): all outputs 0 immediately. SETTLE = 4 rerun: done at k + 8*6 + 1 = k+49.

Source files
------------

// File: rtl/circuit_sweep_ctrl_pkg.sv
// Shared types and constants for exhaustive combinational-circuit sweep controllers.
package circuit_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int unsigned SETTLE_W = 4;

  // Truth table of Circuit5: out = ~(A&B) | (B&C), bit i = out for vector i.
  localparam logic [7:0] CIRCUIT5_EXPECT = 8'hBF;

  function automatic int unsigned n_vectors(input int unsigned n_in);
    return 32'(1) << n_in;
  endfunction

endpackage

// File: rtl/circuit_sweep_ctrl_if.sv
// Board-control and circuit-pin bundle between a sweep controller and its circuit under check.
interface circuit_sweep_ctrl_if #(
  parameter int unsigned N_IN = 3
);

  logic            start;
  logic            abort;
  logic [N_IN-1:0] drive_vec;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] first_fail_idx;

  // Controller side.
  modport master (
    input  start, abort, dut_out,
    output drive_vec, busy, done, pass, err_count, fail_valid, first_fail_idx
  );

  // Board controls plus circuit under check.
  modport slave (
    output start, abort, dut_out,
    input  drive_vec, busy, done, pass, err_count, fail_valid, first_fail_idx
  );

endinterface

// File: rtl/circuit_sweep_ctrl_settle_timer.sv
// Reloadable down-counter; expire_o is high while the count sits at 1.
module settle_timer
  import circuit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] value_i,
  output logic                expire_o
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                expire_q, expire_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
    expire_d = (cnt_d == SETTLE_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// Sweeps every input vector of a small combinational circuit, samples its output after
// a settle delay and compares against a truth table; reports pass, error count, first failure.
module circuit_sweep_ctrl
  import circuit_pkg::*;
#(
  parameter int unsigned               N_IN   = 3,
  parameter int unsigned               SETTLE = 1,
  parameter logic [(1 << N_IN)-1:0]    EXPECT = CIRCUIT5_EXPECT
) (
  input  logic                clk,
  input  logic                rst_n,
  circuit_sweep_ctrl_if.master bus
);

  localparam int unsigned NV   = n_vectors(N_IN);
  localparam int unsigned CW   = N_IN + 1;
  localparam int unsigned LAST = NV - 1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [CW-1:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            load_c;
  logic            expire;
  logic            mismatch_c;

  settle_timer u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_c),
    .value_i  (SETTLE_W'(SETTLE)),
    .expire_o (expire)
  );

  assign mismatch_c = (bus.dut_out != EXPECT[idx_q]);

  // Next-state and registered-output logic; abort overrides every non-idle transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    load_c  = 1'b0;

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
      vec_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d = DRIVE;
            idx_d   = '0;
            err_d   = '0;
            fv_d    = 1'b0;
            ff_d    = '0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        DRIVE: begin
          vec_d   = idx_q;
          load_c  = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          if (expire) begin
            state_d = SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch_c) begin
            if (err_q != CW'(NV)) begin
              err_d = err_q + CW'(1);
            end
            if (!fv_q) begin
              fv_d = 1'b1;
              ff_d = idx_q;
            end
          end
          // Last vector leaves idx untouched so it never wraps mid-sweep.
          if (idx_q == N_IN'(LAST)) begin
            state_d = DONE;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + N_IN'(1);
            state_d = DRIVE;
          end
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b1;
          pass_d  = (err_q == '0);
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  assign bus.drive_vec      = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.fail_valid     = fv_q;
  assign bus.first_fail_idx = ff_q;

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Bench for circuit_sweep_ctrl: two controllers (settle 1 and 4) sweeping a modelled Circuit5
// or a configurable faulty circuit, with directed tables, corner sequences and random truth tables.
module tb_circuit_sweep_ctrl;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  int   mode;          // 0 real Circuit5, 1 tied 1, 2 tied 0, 3 arbitrary table tt
  logic [7:0] tt;
  bit   sel;           // which controller the checks look at: 0 -> settle 1, 1 -> settle 4
  int   checks;
  int   errors;

  circuit_sweep_ctrl_if #(.N_IN(3)) bus1 ();
  circuit_sweep_ctrl_if #(.N_IN(3)) bus4 ();

  circuit_sweep_ctrl #(.N_IN(3), .SETTLE(1), .EXPECT(8'hBF)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  circuit_sweep_ctrl #(.N_IN(3), .SETTLE(4), .EXPECT(8'hBF)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic circ5(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return ~(a & b) | (b & c);
  endfunction

  function automatic logic circuit(input int m, input logic [7:0] t, input logic [2:0] v);
    case (m)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return t[v];
      default: return circ5(v);
    endcase
  endfunction

  logic b1_out, b4_out;
  always_comb begin
    b1_out = circuit(mode, tt, bus1.drive_vec);
    b4_out = circuit(mode, tt, bus4.drive_vec);
  end

  assign bus1.start = start;
  assign bus1.abort = abort;
  assign bus1.dut_out = b1_out;
  assign bus4.start = start;
  assign bus4.abort = abort;
  assign bus4.dut_out = b4_out;

  logic       t_busy, t_done, t_pass, t_fv;
  logic [2:0] t_vec, t_ff;
  logic [3:0] t_err;
  always_comb begin
    t_busy = sel ? bus4.busy           : bus1.busy;
    t_done = sel ? bus4.done           : bus1.done;
    t_pass = sel ? bus4.pass           : bus1.pass;
    t_fv   = sel ? bus4.fail_valid     : bus1.fail_valid;
    t_vec  = sel ? bus4.drive_vec      : bus1.drive_vec;
    t_ff   = sel ? bus4.first_fail_idx : bus1.first_fail_idx;
    t_err  = sel ? bus4.err_count      : bus1.err_count;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: count table entries that disagree with the Circuit5 formula.
  task automatic ref_sweep(input int m, input logic [7:0] t, output int e, output int f);
    e = 0;
    f = 0;
    for (int v = 7; v >= 0; v--) begin
      if (circuit(m, t, 3'(v)) != circ5(3'(v))) begin
        e++;
        f = v;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus1.busy || bus4.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  // Full sweep on the selected controller; xs >= 0 pulses start again at that cycle.
  task automatic run_sweep(input string nm, input int p, input int xs,
                           input int ee, input int ef, input bit efv, input bit ep);
    int busy_n, done_at, n_done, vbad, expv;
    wait_idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; done_at = -1; n_done = 0; vbad = 0;
    for (int c = 0; c < 8 * p + 20; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == xs);
      if (t_busy) busy_n++;
      if (t_done) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (c >= 1) begin
        expv = (c - 1) / p;
        if (expv > 7) expv = 7;
        if (int'(t_vec) != expv) vbad++;
      end
      if (done_at >= 0 && c >= done_at + 3) break;
    end
    start = 1'b0;
    chk({nm, " done_cycle"}, done_at, 8 * p + 1);
    chk({nm, " busy_cycles"}, busy_n, 8 * p);
    chk({nm, " done_pulses"}, n_done, 1);
    chk({nm, " drive_vec_seq_bad"}, vbad, 0);
    chk({nm, " err_count"}, int'(t_err), ee);
    chk({nm, " fail_valid"}, int'(t_fv), int'(efv));
    if (efv) chk({nm, " first_fail_idx"}, int'(t_ff), ef);
    chk({nm, " pass"}, int'(t_pass), int'(ep));
  endtask

  typedef struct {
    string      nm;
    int         m;
    logic [7:0] t;
    bit         s;
    int         xs;
    int         ee;
    int         ef;
    bit         efv;
    bit         ep;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n_done, e, f;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0; tt = 8'h00; sel = 1'b0;

    tbl[0] = '{"golden",        0, 8'h00, 1'b0, -1, 0, 0, 1'b0, 1'b1};
    tbl[1] = '{"stuck1",        1, 8'h00, 1'b0, -1, 1, 6, 1'b1, 1'b0};
    tbl[2] = '{"stuck0",        2, 8'h00, 1'b0, -1, 7, 0, 1'b1, 1'b0};
    tbl[3] = '{"start_busy",    0, 8'h00, 1'b0, 13, 0, 0, 1'b0, 1'b1};
    tbl[4] = '{"tt_bit7",       3, 8'h3F, 1'b0, -1, 1, 7, 1'b1, 1'b0};
    tbl[5] = '{"tt_inverted",   3, 8'h40, 1'b0, -1, 8, 0, 1'b1, 1'b0};
    tbl[6] = '{"s4_stuck0",     2, 8'h00, 1'b1, -1, 7, 0, 1'b1, 1'b0};
    tbl[7] = '{"s4_tt_bit0",    3, 8'hBE, 1'b1, -1, 1, 0, 1'b1, 1'b0};

    #12;
    chk("reset busy",  int'(bus1.busy) + int'(bus4.busy), 0);
    chk("reset done",  int'(bus1.done) + int'(bus4.done), 0);
    chk("reset pass",  int'(bus1.pass) + int'(bus4.pass), 0);
    chk("reset err",   int'(bus1.err_count) + int'(bus4.err_count), 0);
    chk("reset fv",    int'(bus1.fail_valid) + int'(bus4.fail_valid), 0);
    chk("reset vec",   int'(bus1.drive_vec) + int'(bus4.drive_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].m; tt = tbl[i].t; sel = tbl[i].s;
      run_sweep(tbl[i].nm, sel ? 6 : 3, tbl[i].xs, tbl[i].ee, tbl[i].ef, tbl[i].efv, tbl[i].ep);
    end

    // start and abort together in IDLE: abort wins.
    wait_idle();
    sel = 1'b0; mode = 0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle busy", int'(bus1.busy) + int'(bus4.busy), 0);
    repeat (4) @(negedge clk);
    chk("start_abort_idle busy_later", int'(bus1.busy) + int'(bus4.busy), 0);

    // abort during WAIT of vector 3 keeps partial counts, no done pulse.
    wait_idle();
    sel = 1'b0; mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort pre vec", int'(t_vec), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", int'(t_busy), 0);
    chk("abort drive_vec", int'(t_vec), 0);
    chk("abort err_partial", int'(t_err), 3);
    chk("abort fv_partial", int'(t_fv), 1);
    chk("abort pass", int'(t_pass), 0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus1.done) n_done++;
    end
    chk("abort no_done", n_done, 0);
    mode = 0;
    run_sweep("after_abort", 3, -1, 0, 0, 1'b0, 1'b1);

    // Async reset in SAMPLE of vector 2.
    wait_idle();
    sel = 1'b0; mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst pre err", int'(t_err), 2);
    rst_n = 1'b0;
    #1;
    chk("rst busy", int'(t_busy), 0);
    chk("rst vec", int'(t_vec), 0);
    chk("rst err", int'(t_err), 0);
    chk("rst fv", int'(t_fv), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus1.done || bus4.done) n_done++;
    end
    chk("rst no_done", n_done, 0);
    mode = 0; sel = 1'b1;
    run_sweep("s4_golden", 6, -1, 0, 0, 1'b0, 1'b1);

    // Random truth tables against the formula-based reference.
    for (int r = 0; r < 10; r++) begin
      mode = 3;
      tt = 8'($urandom);
      sel = 1'($urandom_range(0, 1));
      ref_sweep(mode, tt, e, f);
      run_sweep($sformatf("rand%0d_tt%02h", r, tt), sel ? 6 : 3, -1, e, f, e > 0, e == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
